// File: rtl/ascii_scroll_display_pkg.sv
// Shared types, constants and the ASCII-to-7-segment glyph table for the scrolling message display.
package ascii_disp_pkg;

  typedef logic [7:0] ascii_t;
  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {
    S_STATIC,
    S_SCROLL,
    S_PAUSE
  } scroll_state_t;

  localparam seg_t   SEG_BLANK   = 7'h7F;
  localparam ascii_t ASCII_SPACE = 8'h20;

  // Glyphs are built active-high {g..a} and inverted once on return; lower case folds onto upper case.
  function automatic seg_t ascii_to_seg(input ascii_t c);
    ascii_t u;
    seg_t   on;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    // NOTE: the default arm gives 'on' a value on every path, so no latch can be inferred.
    case (u)
      8'h30: on = 7'h3F;  8'h31: on = 7'h06;  8'h32: on = 7'h5B;  8'h33: on = 7'h4F;
      8'h34: on = 7'h66;  8'h35: on = 7'h6D;  8'h36: on = 7'h7D;  8'h37: on = 7'h07;
      8'h38: on = 7'h7F;  8'h39: on = 7'h6F;
      8'h41: on = 7'h77;  8'h42: on = 7'h7C;  8'h43: on = 7'h39;  8'h44: on = 7'h5E;
      8'h45: on = 7'h79;  8'h46: on = 7'h71;  8'h47: on = 7'h3D;  8'h48: on = 7'h76;
      8'h49: on = 7'h30;  8'h4A: on = 7'h1E;  8'h4B: on = 7'h75;  8'h4C: on = 7'h38;
      8'h4D: on = 7'h37;  8'h4E: on = 7'h54;  8'h4F: on = 7'h3F;  8'h50: on = 7'h73;
      8'h51: on = 7'h67;  8'h52: on = 7'h50;  8'h53: on = 7'h6D;  8'h54: on = 7'h78;
      8'h55: on = 7'h3E;  8'h56: on = 7'h1C;  8'h57: on = 7'h2A;  8'h58: on = 7'h76;
      8'h59: on = 7'h6E;  8'h5A: on = 7'h5B;
      8'h2D: on = 7'h40;  8'h5F: on = 7'h08;
      default: on = 7'h00;
    endcase
    return ~on;
  endfunction

endpackage

// File: rtl/ascii_scroll_display_if.sv
// Key/switch/write-port bundle and HEX outputs of the scrolling display; master drives, slave is the display.
interface ascii_scroll_display_if #(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 16
);
  import ascii_disp_pkg::*;

  localparam int ADDR_W = $clog2(MSG_LEN);

  logic                    KeySel;
  logic                    ScrollEn;
  logic                    WrEn;
  logic                    WrSel;
  logic [ADDR_W-1:0]       WrAddr;
  ascii_t                  WrData;
  seg_t [NUM_DIGITS-1:0]   HexSeg;
  logic [ADDR_W-1:0]       Pos;

  modport master (
    output KeySel, ScrollEn, WrEn, WrSel, WrAddr, WrData,
    input  HexSeg, Pos
  );

  modport slave (
    input  KeySel, ScrollEn, WrEn, WrSel, WrAddr, WrData,
    output HexSeg, Pos
  );

endinterface

// File: rtl/ascii_scroll_display_decoder.sv
// Combinational ASCII-to-segment decoder for one digit; one instance per displayed digit.
module ascii_seg_decoder
  import ascii_disp_pkg::*;
(
  input  ascii_t ascii,
  output seg_t   seg
);

  assign seg = ascii_to_seg(ascii);

endmodule

// File: rtl/ascii_scroll_display.sv
// Two writable ASCII message buffers shown on NUM_DIGITS 7-seg digits, static or circularly scrolled.
// Optional hold at Pos 0 after each wrap is enabled with `define ASCII_SCROLL_PAUSE_EN.
module ascii_scroll_display
  import ascii_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int MSG_LEN     = 16,
  parameter int TICK_DIV    = 50000000,
  parameter int PAUSE_TICKS = 3
) (
  input logic                   Clk,
  input logic                   ResetN,
  ascii_scroll_display_if.slave bus
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int PW = $clog2(TICK_DIV);

  if (MSG_LEN < NUM_DIGITS) begin : g_bad_len
    $error("MSG_LEN must be >= NUM_DIGITS");
  end
  if (TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be >= 2");
  end
  if (PAUSE_TICKS < 1) begin : g_bad_pause
    $error("PAUSE_TICKS must be >= 1");
  end

  logic key_meta, key_sync, key_prev;
  logic sel_change;

  ascii_t          mem [2][MSG_LEN];
  scroll_state_t   state;
  logic [AW-1:0]   pos;
  logic [AW-1:0]   pos_view;
  logic [PW-1:0]   presc;
  logic            tick;
  seg_t [NUM_DIGITS-1:0] dec_seg;
  seg_t [NUM_DIGITS-1:0] seg_q;

`ifdef ASCII_SCROLL_PAUSE_EN
  localparam int CW = $clog2(PAUSE_TICKS + 1);
  logic [CW-1:0] pause_cnt;
`endif

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      key_meta <= 1'b0;
      key_sync <= 1'b0;
      key_prev <= 1'b0;
    end else begin
      key_meta <= bus.KeySel;
      key_sync <= key_meta;
      key_prev <= key_sync;
    end
  end

  assign sel_change = key_sync ^ key_prev;

  // NOTE: the buffers are reset on purpose: a reset must blank the display, so storage cannot be plain RAM.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < MSG_LEN; i++)
          mem[b][i] <= ASCII_SPACE;
    end else if (bus.WrEn && int'(bus.WrAddr) < MSG_LEN) begin
      mem[bus.WrSel][bus.WrAddr] <= bus.WrData;
    end
  end

  assign tick = (state != S_STATIC) && (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state <= S_STATIC;
      pos   <= '0;
      presc <= '0;
`ifdef ASCII_SCROLL_PAUSE_EN
      pause_cnt <= '0;
`endif
    end else begin
      case (state)
        S_SCROLL: begin
          if (!bus.ScrollEn) begin
            state <= S_STATIC;
            pos   <= '0;
            presc <= '0;
          end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
              if (pos == AW'(MSG_LEN - 1)) begin
                pos <= '0;
`ifdef ASCII_SCROLL_PAUSE_EN
                state     <= S_PAUSE;
                pause_cnt <= '0;
`endif
              end else begin
                pos <= pos + 1'b1;
              end
            end
          end
        end
`ifdef ASCII_SCROLL_PAUSE_EN
        S_PAUSE: begin
          pos <= '0;
          if (!bus.ScrollEn) begin
            state <= S_STATIC;
            presc <= '0;
          end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
              if (pause_cnt == CW'(PAUSE_TICKS - 1)) state <= S_SCROLL;
              else                                   pause_cnt <= pause_cnt + 1'b1;
            end
          end
        end
`endif
        default: begin
          pos   <= '0;
          presc <= '0;
          if (bus.ScrollEn) state <= S_SCROLL;
        end
      endcase
      // A message switch restarts the window and the step timer, overriding any same-cycle tick.
      if (sel_change) begin
        pos   <= '0;
        presc <= '0;
      end
    end
  end

  // During the switch cycle the window is taken at Pos 0 so the new message lands aligned in one step.
  assign pos_view = sel_change ? '0 : pos;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    logic [AW:0]   raw_idx;
    logic [AW:0]   idx;
    ascii_t        ch;

    assign raw_idx = {1'b0, pos_view} + (AW + 1)'(NUM_DIGITS - 1 - d);
    assign idx     = (raw_idx >= (AW + 1)'(MSG_LEN)) ? raw_idx - (AW + 1)'(MSG_LEN) : raw_idx;
    assign ch      = mem[key_sync][idx[AW-1:0]];

    ascii_seg_decoder u_dec (
      .ascii (ch),
      .seg   (dec_seg[d])
    );
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) seg_q <= {NUM_DIGITS{SEG_BLANK}};
    else         seg_q <= dec_seg;
  end

  assign bus.HexSeg = seg_q;
  assign bus.Pos    = pos;

endmodule

// File: tb/tb_ascii_scroll_display.sv
// Directed bench for ascii_scroll_display (6 digits, 8-char buffers, 4-clock step, 2-step pause).
module tb_ascii_scroll_display;
  import ascii_disp_pkg::*;

  localparam int ND = 6;
  localparam int ML = 8;
  localparam int TD = 4;
  localparam int PT = 2;

  localparam logic [41:0] W_HELLO1 = {7'h09, 7'h06, 7'h47, 7'h47, 7'h40, 7'h79};
  localparam logic [41:0] W_3HELLO = {7'h30, 7'h09, 7'h06, 7'h47, 7'h47, 7'h40};
  localparam logic [41:0] W_KJC00  = {7'h0A, 7'h61, 7'h46, 7'h40, 7'h40, 7'h7F};
  localparam logic [41:0] W_E00    = {7'h06, 7'h40, 7'h40, 7'h7F, 7'h7F, 7'h7F};
  localparam logic [41:0] W_BLANK  = {6{7'h7F}};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;

  ascii_t m0 [ML];
  ascii_t m1 [ML];

  ascii_scroll_display_if #(.NUM_DIGITS(ND), .MSG_LEN(ML)) bus ();

  ascii_scroll_display #(
    .NUM_DIGITS (ND),
    .MSG_LEN    (ML),
    .TICK_DIV   (TD),
    .PAUSE_TICKS(PT)
  ) dut (
    .Clk    (clk),
    .ResetN (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic seg_t glyph(input ascii_t c);
    case (c)
      8'h48: return 7'h09;  8'h45: return 7'h06;  8'h4C: return 7'h47;
      8'h4F: return 7'h40;  8'h30: return 7'h40;  8'h31: return 7'h79;
      8'h32: return 7'h24;  8'h33: return 7'h30;  8'h4B: return 7'h0A;
      8'h4A: return 7'h61;  8'h43: return 7'h46;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [41:0] win(input bit s, input int p);
    logic [41:0] w;
    ascii_t ch;
    w = '0;
    for (int d = 0; d < ND; d++) begin
      ch = s ? m1[(p + ND - 1 - d) % ML] : m0[(p + ND - 1 - d) % ML];
      w[d*7 +: 7] = glyph(ch);
    end
    return w;
  endfunction

  task automatic wr(input bit s, input int a, input ascii_t data);
    bus.WrEn   = 1'b1;
    bus.WrSel  = s;
    bus.WrAddr = 3'(a);
    bus.WrData = data;
    step();
    bus.WrEn = 1'b0;
    if (s) m1[a] = data;
    else   m0[a] = data;
  endtask

  task automatic wait_pos(input string tag, input int v, input int budget);
    int n;
    n = 0;
    while (int'(bus.Pos) != v && n < budget) begin
      step();
      n++;
    end
    check(tag, 64'(bus.Pos), 64'(v));
  endtask

  initial begin
    logic [41:0] old_win;
    ascii_t msg1 [ML];
    ascii_t msg0 [ML];
    msg1 = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h31, 8'h32, 8'h33};
    msg0 = '{8'h4B, 8'h4A, 8'h43, 8'h30, 8'h30, 8'h20, 8'h20, 8'h20};
    for (int i = 0; i < ML; i++) begin
      m0[i] = 8'h20;
      m1[i] = 8'h20;
    end
    bus.KeySel = 1'b0; bus.ScrollEn = 1'b0; bus.WrEn = 1'b0;
    bus.WrSel = 1'b0; bus.WrAddr = '0; bus.WrData = '0;

    // Reset asserted between edges takes effect with no clock
    #2 rst_n = 1'b0;
    #1;
    check("reset_async_seg", 64'(bus.HexSeg), 64'(W_BLANK));
    check("reset_async_pos", 64'(bus.Pos), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(); step();
    check("post_reset_blank", 64'(bus.HexSeg), 64'(W_BLANK));

    for (int i = 0; i < ML; i++) wr(1'b1, i, msg1[i]);
    for (int i = 0; i < ML; i++) wr(1'b0, i, msg0[i]);
    step();
    check("msg0_static", 64'(bus.HexSeg), 64'(W_KJC00));

    // Select msg1: visible exactly 3 cycles after KeySel changes
    bus.KeySel = 1'b1;
    step(); step();
    check("sel_latency_old", 64'(bus.HexSeg), 64'(win(1'b0, 0)));
    step();
    check("sel_latency_new", 64'(bus.HexSeg), 64'(W_HELLO1));
    check("static_pos", 64'(bus.Pos), 64'd0);
    repeat (10) step();
    check("static_hold_pos", 64'(bus.Pos), 64'd0);
    check("static_hold_seg", 64'(bus.HexSeg), 64'(win(1'b1, 0)));

    // Scroll: one step every TD clocks through the whole buffer
    bus.ScrollEn = 1'b1;
    wait_pos("scroll_start", 1, 10);
    for (int p = 1; p < ML; p++) begin
      step();
      check("scroll_win", 64'(bus.HexSeg), 64'(win(1'b1, p)));
      step(); step();
      check("scroll_hold", 64'(bus.Pos), 64'(p));
      step();
      check("scroll_step", 64'(bus.Pos), 64'((p + 1) % ML));
    end
    check("wrap_window", 64'(bus.HexSeg), 64'(W_3HELLO));

`ifdef ASCII_SCROLL_PAUSE_EN
    repeat (11) step();
    check("pause_hold", 64'(bus.Pos), 64'd0);
    step();
    check("pause_exit", 64'(bus.Pos), 64'd1);
`else
    repeat (3) step();
    check("wrap_hold", 64'(bus.Pos), 64'd0);
    step();
    check("wrap_next", 64'(bus.Pos), 64'd1);
`endif

    // Switch to msg0 mid-scroll: window and step timer restart
    wait_pos("reach_pos4", 4, 40);
    bus.KeySel = 1'b0;
    step(); step(); step();
    check("sel_mid_pos", 64'(bus.Pos), 64'd0);
    check("sel_mid_seg", 64'(bus.HexSeg), 64'(W_KJC00));
    repeat (3) step();
    check("sel_presc_hold", 64'(bus.Pos), 64'd0);
    step();
    check("sel_presc_step", 64'(bus.Pos), 64'd1);

    // Write the character entering digit 5 in the same cycle as the tick
    repeat (3) step();
    old_win = win(1'b0, 1);
    wr(1'b0, 2, 8'h45);
    check("collide_pos", 64'(bus.Pos), 64'd2);
    check("collide_old", 64'(bus.HexSeg), 64'(old_win));
    step();
    check("collide_new", 64'(bus.HexSeg), 64'(W_E00));

    // Writing the hidden buffer leaves the display alone
    wr(1'b1, 3, 8'h4B);
    step();
    check("hidden_write", 64'(bus.HexSeg), 64'(win(1'b0, 2)));

    // ScrollEn drops in the tick cycle: static wins
    bus.ScrollEn = 1'b0;
    step();
    check("stop_on_tick", 64'(bus.Pos), 64'd0);
    step();
    check("stop_window", 64'(bus.HexSeg), 64'(win(1'b0, 0)));
    repeat (6) step();
    check("stop_hold", 64'(bus.Pos), 64'd0);

    // Reset while scrolling clears everything, including buffer contents
    bus.KeySel   = 1'b1;
    bus.ScrollEn = 1'b1;
    wait_pos("reach_pos3", 3, 60);
    #2 rst_n = 1'b0;
    #1;
    check("midscroll_reset_pos", 64'(bus.Pos), 64'd0);
    check("midscroll_reset_seg", 64'(bus.HexSeg), 64'(W_BLANK));
    @(negedge clk);
    bus.ScrollEn = 1'b0;
    rst_n = 1'b1;
    repeat (4) step();
    check("buffers_lost", 64'(bus.HexSeg), 64'(W_BLANK));
    check("post_reset_pos", 64'(bus.Pos), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
